// File: rtl/dma_channel_scheduler_if.sv
// Engine-side handshake of the DMA channel scheduler: one descriptor issued at
// a time, completion reported back with done/error.
interface dma_channel_scheduler_if #(
  parameter int DESC_W = 144
);
  logic              eng_start;
  logic [1:0]        eng_channel_sel;
  logic [DESC_W-1:0] eng_descriptor;
  logic              eng_busy;
  logic              eng_done;
  logic              eng_error;

  modport master (
    output eng_start, eng_channel_sel, eng_descriptor,
    input  eng_busy, eng_done, eng_error
  );

  modport slave (
    input  eng_start, eng_channel_sel, eng_descriptor,
    output eng_busy, eng_done, eng_error
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Per-channel descriptor FIFOs with round-robin issue to the single-transfer
// DMA engine; retires each job with per-channel done / sticky error status.
module dma_channel_scheduler #(
  parameter int NUM_CHANNELS   = 4,
  parameter int DESC_W         = 144,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic [NUM_CHANNELS-1:0]                        ch_push,
  input  logic [NUM_CHANNELS*DESC_W-1:0]                 ch_desc_in,
  input  logic [NUM_CHANNELS-1:0]                        ch_enable,
  input  logic [NUM_CHANNELS-1:0]                        ch_err_clear,
  output logic [NUM_CHANNELS-1:0]                        ch_full,
  output logic [NUM_CHANNELS*($clog2(QUEUE_DEPTH)+1)-1:0] ch_level,
  output logic [NUM_CHANNELS-1:0]                        ch_done,
  output logic [NUM_CHANNELS-1:0]                        ch_err,
  output logic [NUM_CHANNELS-1:0]                        ch_timeout,
  dma_channel_scheduler_if.master                        eng,
  output logic                                           sched_busy
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int LEVEL_W = PTR_W + 1;
  localparam int CH_W    = $clog2(NUM_CHANNELS);
  localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

  state_t             state;
  logic [CH_W-1:0]    grant;
  logic [CH_W-1:0]    rr_ptr;
  logic               err_seen;
  logic               timeout_seen;
  logic [WD_W-1:0]    wd_cnt;

  logic [DESC_W-1:0]  mem    [NUM_CHANNELS][QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_CHANNELS];
  logic [PTR_W-1:0]   rd_ptr [NUM_CHANNELS];
  logic [LEVEL_W-1:0] count  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] push_ok;
  logic [NUM_CHANNELS-1:0] pop;
  logic [NUM_CHANNELS-1:0] request;
  logic                    issue_fire;
  logic                    any_req;
  logic [CH_W-1:0]         next_grant;
  logic [WD_W-1:0]         wd_next;
  logic                    timeout_hit;
  logic                    err_next;
  logic                    to_next;

  assign issue_fire    = (state == ISSUE) && !eng.eng_busy;
  assign eng.eng_start = issue_fire;
  assign sched_busy    = (state != IDLE);

  assign wd_next     = wd_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state == WAIT) &&
                       (wd_next >= WD_W'(TIMEOUT_CYCLES));
  // Done and error in the same cycle retire as an error.
  assign err_next    = err_seen | eng.eng_error | timeout_hit;
  assign to_next     = timeout_seen | timeout_hit;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    push_ok  = '0;
    pop      = '0;
    request  = '0;
    ch_full  = '0;
    ch_level = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      ch_full[i]                       = (count[i] == LEVEL_W'(QUEUE_DEPTH));
      ch_level[i*LEVEL_W +: LEVEL_W]   = count[i];
      push_ok[i]                       = ch_push[i] && !ch_full[i];
      pop[i]                           = issue_fire && (grant == CH_W'(i));
      request[i]                       = (count[i] != '0) && ch_enable[i] && !ch_err[i];
    end
  end

  // Round-robin search from rr_ptr upward; walking offsets downward lets the
  // nearest requester overwrite any farther one.
  always_comb begin
    next_grant = '0;
    any_req    = 1'b0;
    for (int off = NUM_CHANNELS - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(rr_ptr) + off) % NUM_CHANNELS;
      if (request[idx]) begin
        next_grant = CH_W'(idx);
        any_req    = 1'b1;
      end
    end
  end

  // NOTE: descriptor storage is deliberately not reset; the pointers and counts alone decide validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= ch_desc_in[i*DESC_W +: DESC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push_ok[i], pop[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      grant               <= '0;
      rr_ptr              <= '0;
      err_seen            <= 1'b0;
      timeout_seen        <= 1'b0;
      wd_cnt              <= '0;
      ch_done             <= '0;
      ch_err              <= '0;
      ch_timeout          <= '0;
      eng.eng_channel_sel <= '0;
      eng.eng_descriptor  <= '0;
    end else begin
      ch_done <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (ch_err_clear[i]) begin
          ch_err[i]     <= 1'b0;
          ch_timeout[i] <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            grant               <= next_grant;
            eng.eng_channel_sel <= next_grant;
            eng.eng_descriptor  <= mem[next_grant][rd_ptr[next_grant]];
            state               <= ISSUE;
          end
        end

        ISSUE: begin
          if (!eng.eng_busy) begin
            err_seen     <= 1'b0;
            timeout_seen <= 1'b0;
            // The start cycle counts as the first elapsed watchdog cycle.
            wd_cnt       <= WD_W'(1);
            state        <= WAIT;
          end
        end

        WAIT: begin
          err_seen     <= err_next;
          timeout_seen <= to_next;
          wd_cnt       <= wd_next;
          if (eng.eng_done || timeout_hit) begin
            // NOTE: these follow the clear loop above, so a coinciding set wins over a clear.
            ch_done[grant] <= 1'b1;
            if (err_next) ch_err[grant]     <= 1'b1;
            if (to_next)  ch_timeout[grant] <= 1'b1;
            rr_ptr <= grant + 1'b1;
            state  <= RETIRE;
          end
        end

        RETIRE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler: the bench plays the engine and
// checks issue order, latencies, FIFO limits, error/timeout and reset.
module tb_dma_channel_scheduler;
  localparam int NC = 4;
  localparam int DW = 144;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0]    ch_push = '0;
  logic [NC*DW-1:0] ch_desc_in = '0;
  logic [NC-1:0]    ch_enable = '1;
  logic [NC-1:0]    ch_err_clear = '0;
  logic [NC-1:0]    ch_full, ch_done, ch_err, ch_timeout;
  logic [NC*3-1:0]  ch_level;
  logic             sched_busy;

  dma_channel_scheduler_if #(.DESC_W(DW)) eng ();

  dma_channel_scheduler #(
    .NUM_CHANNELS(NC), .DESC_W(DW), .QUEUE_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ch_push(ch_push), .ch_desc_in(ch_desc_in),
    .ch_enable(ch_enable), .ch_err_clear(ch_err_clear), .ch_full(ch_full),
    .ch_level(ch_level), .ch_done(ch_done), .ch_err(ch_err),
    .ch_timeout(ch_timeout), .eng(eng), .sched_busy(sched_busy)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int done_pulses = 0;

  always @(negedge clk) done_pulses = done_pulses + $countones(ch_done);

  function automatic logic [DW-1:0] mk(input logic [31:0] src, input logic [31:0] len,
                                       input logic rd);
    return {48'd0, len, src, 31'd0, rd};
  endfunction

  function automatic logic [DW-1:0] mkd(input int ch, input int n);
    return mk(32'h1000 * (ch + 1) + n * 64, 32'd64 + n, n[0]);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_one(input int ch, input logic [DW-1:0] d);
    ch_push = '0;
    ch_push[ch] = 1'b1;
    ch_desc_in[ch*DW +: DW] = d;
    tick();
    ch_push = '0;
  endtask

  task automatic push_n(input logic [NC-1:0] mask, input int n);
    ch_push = mask;
    for (int c = 0; c < NC; c++) ch_desc_in[c*DW +: DW] = mkd(c, n);
    tick();
    ch_push = '0;
  endtask

  // Returns the number of cycles waited for eng_start; an expired bound is a failure.
  task automatic wait_start(output int waited);
    waited = 0;
    #1;
    while (!eng.eng_start && waited < 40) begin
      tick();
      waited++;
    end
    chk("start_seen", eng.eng_start, 1);
  endtask

  // Play one engine transfer: done `dur` cycles after start, optional error pulse.
  task automatic run_job(input string tag, input int ch, input logic [DW-1:0] d,
                         input int dur, input int err_at, input int exp_wait);
    int w;
    wait_start(w);
    if (exp_wait >= 0) chk({tag, "_lat"}, w, exp_wait);
    chk({tag, "_sel"}, eng.eng_channel_sel, ch);
    chk({tag, "_desc"}, eng.eng_descriptor, d);
    for (int k = 1; k <= dur; k++) begin
      tick();
      eng.eng_busy  = (k < dur);
      eng.eng_done  = (k == dur);
      eng.eng_error = (k == err_at);
    end
    tick();
    eng.eng_done  = 1'b0;
    eng.eng_error = 1'b0;
    chk({tag, "_done"}, ch_done, 4'b0001 << ch);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int  w;
    int  snap;
    logic flag;
    eng.eng_busy = 1'b0;
    eng.eng_done = 1'b0;
    eng.eng_error = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_flags", {ch_full, ch_done, ch_err, ch_timeout, eng.eng_start, sched_busy}, 0);
    chk("rst_level", ch_level, 0);
    chk("rst_eng", {eng.eng_channel_sel, eng.eng_descriptor}, 0);
    rst_n = 1'b1;
    tick();

    // Single job on ch2: start two edges after the push edge, retire after done.
    push_one(2, mk(32'h1000, 32'd64, 1'b1));
    chk("t1_level", ch_level, 12'h040);
    chk("t1_no_start", eng.eng_start, 0);
    run_job("t1", 2, mk(32'h1000, 32'd64, 1'b1), 10, 0, 1);
    chk("t1_err", ch_err, 0);
    tick();
    chk("t1_done_off", ch_done, 0);
    chk("t1_idle", sched_busy, 0);

    // Round-robin over four loaded channels.
    do_reset();
    snap = done_pulses;
    push_n(4'hF, 0);
    push_n(4'hF, 1);
    chk("rr_levels", ch_level, 12'b010_010_010_010);
    for (int i = 0; i < 8; i++)
      run_job($sformatf("rr%0d", i), i % 4, mkd(i % 4, i / 4), 5, 0, (i == 0) ? 0 : 2);
    tick();
    tick();
    chk("rr_pulses", done_pulses - snap, 8);
    chk("rr_drained", ch_level, 0);

    // Overflow of ch1 while the engine is busy.
    eng.eng_busy = 1'b1;
    for (int j = 0; j < 4; j++) push_one(1, mkd(1, j));
    chk("full_flag", ch_full, 4'b0010);
    chk("full_level", ch_level, 12'h020);
    push_one(1, mkd(1, 4));
    chk("full_drop", ch_level, 12'h020);
    chk("hold_start", eng.eng_start, 0);
    chk("hold_busy", sched_busy, 1);
    eng.eng_busy = 1'b0;
    for (int j = 0; j < 4; j++)
      run_job($sformatf("full%0d", j), 1, mkd(1, j), 3, 0, (j == 0) ? 0 : 2);
    flag = 1'b0;
    repeat (12) begin
      tick();
      if (eng.eng_start) flag = 1'b1;
    end
    chk("full_no_fifth", flag, 0);
    chk("full_clear", {ch_full, ch_level}, 0);

    // Bus error on ch0 faults it; ch1 proceeds; clearing resumes ch0.
    push_n(4'b0011, 0);
    push_one(0, mkd(0, 1));
    run_job("err0", 0, mkd(0, 0), 6, 2, 0);
    chk("err_set", ch_err, 4'b0001);
    chk("err_no_to", ch_timeout, 0);
    run_job("err1", 1, mkd(1, 0), 4, 0, 2);
    flag = 1'b0;
    repeat (12) begin
      tick();
      if (eng.eng_start) flag = 1'b1;
    end
    chk("err_blocked", flag, 0);
    chk("err_kept", ch_level, 12'h001);
    ch_err_clear = 4'b0001;
    tick();
    ch_err_clear = '0;
    chk("err_cleared", ch_err, 0);
    run_job("err2", 0, mkd(0, 1), 3, 0, 1);

    // Watchdog: no done, engine stays busy.
    push_one(3, mkd(3, 0));
    wait_start(w);
    chk("to_lat", w, 1);
    chk("to_sel", eng.eng_channel_sel, 3);
    flag = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      eng.eng_busy = 1'b1;
      if (ch_done != '0) flag = 1'b1;
    end
    tick();
    chk("to_early", flag, 0);
    chk("to_done", ch_done, 4'b1000);
    chk("to_err", ch_err, 4'b1000);
    chk("to_flag", ch_timeout, 4'b1000);

    // Next issue still waits for the engine to go idle.
    push_one(2, mkd(2, 0));
    flag = 1'b0;
    repeat (5) begin
      tick();
      if (eng.eng_start) flag = 1'b1;
    end
    chk("bh_no_start", flag, 0);
    chk("bh_busy", sched_busy, 1);
    eng.eng_busy = 1'b0;
    run_job("bh", 2, mkd(2, 0), 4, 0, 0);

    // Asynchronous reset in the middle of a transfer.
    push_one(1, mkd(1, 5));
    push_one(1, mkd(1, 6));
    wait_start(w);
    chk("mr_lat", w, 0);
    tick();
    eng.eng_busy = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_flags", {ch_full, ch_done, ch_err, ch_timeout, eng.eng_start, sched_busy}, 0);
    chk("mr_level", ch_level, 0);
    chk("mr_eng", {eng.eng_channel_sel, eng.eng_descriptor}, 0);
    eng.eng_done = 1'b1;
    tick();
    tick();
    eng.eng_done = 1'b0;
    eng.eng_busy = 1'b0;
    rst_n = 1'b1;
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (ch_done != '0 || eng.eng_start || ch_level != '0) flag = 1'b1;
    end
    chk("mr_quiet", flag, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
